// File: rtl/lab7_seq_pkg.sv
// Shared types and constants for the lab7 program sequencer.
// Instruction: [11:10] class, OP carries the 10 datapath control bits in [9:0].
package lab7_seq_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned CTRL_W  = 10;

  localparam int unsigned WE_BIT     = 9;
  localparam int unsigned SEL_A_LSB  = 7;
  localparam int unsigned SEL_B_LSB  = 5;
  localparam int unsigned ALU_OP_LSB = 3;
  localparam int unsigned IMM_BIT    = 2;
  localparam int unsigned SEL_R_LSB  = 0;

  localparam logic [1:0] CLS_OP   = 2'b00;
  localparam logic [1:0] CLS_JMP  = 2'b01;
  localparam logic [1:0] CLS_BZ   = 2'b10;
  localparam logic [1:0] CLS_HALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       write_enable;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] alu_op;
    logic       imm;
    logic [1:0] sel_r;
  } ctrl_t;

  // Unpack the datapath control fields of an OP instruction.
  function automatic ctrl_t decode_ctrl(input logic [INSTR_W-1:0] instr);
    ctrl_t c;
    c.write_enable = instr[WE_BIT];
    c.sel_a        = instr[SEL_A_LSB  +: 2];
    c.sel_b        = instr[SEL_B_LSB  +: 2];
    c.alu_op       = instr[ALU_OP_LSB +: 2];
    c.imm          = instr[IMM_BIT];
    c.sel_r        = instr[SEL_R_LSB  +: 2];
    return c;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: synchronous write, asynchronous read, contents not reset.
module seq_prog_mem #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lab7_sequencer.sv
// Fetch/execute controller: drives the datapath control fields from a program
// store, two cycles per instruction, resolving JMP/BZ/HALT internally.
module lab7_sequencer
  import lab7_seq_pkg::*;
#(
  parameter int unsigned PC_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic               stop,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               zero_flag,
  output logic               write_enable,
  output logic [1:0]         sel_a,
  output logic [1:0]         sel_b,
  output logic [1:0]         alu_op,
  output logic               imm,
  output logic [1:0]         sel_r,
  output logic               dp_strobe,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted
);

  state_t             state;
  logic               run_mode;
  logic [1:0]         ir_cls;
  logic [PC_W-1:0]    ir_tgt;
  ctrl_t              ctrl;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_inc;
  logic               store_we;

  // Store is writable only while the sequencer is parked.
  assign store_we = prog_we && ((state == IDLE) || (state == HALT));
  assign pc_inc   = pc + PC_W'(1);

  seq_prog_mem #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (store_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_mode  <= 1'b0;
      pc        <= '0;
      ir_cls    <= CLS_OP;
      ir_tgt    <= '0;
      ctrl      <= '0;
      dp_strobe <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start || step) begin
            run_mode <= start;
            state    <= FETCH;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          ir_cls <= instr[INSTR_W-1 -: 2];
          ir_tgt <= instr[PC_W-1:0];
          if (instr[INSTR_W-1 -: 2] == CLS_OP) begin
            ctrl      <= decode_ctrl(instr);
            dp_strobe <= 1'b1;
          end
          state <= EXEC;
        end
        EXEC: begin
          dp_strobe <= 1'b0;
          if (ir_cls == CLS_HALT) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            case (ir_cls)
              CLS_JMP: pc <= ir_tgt;
              CLS_BZ:  pc <= zero_flag ? ir_tgt : pc_inc;
              default: pc <= pc_inc;
            endcase
            if (run_mode && !stop) begin
              state <= FETCH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HALT: begin
          // Restart from address 0; step and stop have no effect here.
          if (start) begin
            pc       <= '0;
            run_mode <= 1'b1;
            state    <= FETCH;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign write_enable = ctrl.write_enable;
  assign sel_a        = ctrl.sel_a;
  assign sel_b        = ctrl.sel_b;
  assign alu_op       = ctrl.alu_op;
  assign imm          = ctrl.imm;
  assign sel_r        = ctrl.sel_r;

endmodule

// File: tb/tb_lab7_sequencer.sv
// Scoreboard bench for lab7_sequencer: expected strobes are queued when a run
// is launched and checked against every dp_strobe cycle.
module tb_lab7_sequencer;

  localparam int unsigned PC_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            step = 1'b0;
  logic            stop = 1'b0;
  logic            prog_we = 1'b0;
  logic [PC_W-1:0] prog_addr = '0;
  logic [11:0]     prog_data = '0;
  logic            zero_flag = 1'b0;
  logic            write_enable;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic [1:0]      alu_op;
  logic            imm;
  logic [1:0]      sel_r;
  logic            dp_strobe;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0]      ctrl;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t sbq[$];
  exp_t got_e;

  logic [11:0] ops [4] = '{12'h155, 12'h2AA, 12'h0F3, 12'h3C1};

  lab7_sequencer #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .step         (step),
    .stop         (stop),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .zero_flag    (zero_flag),
    .write_enable (write_enable),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .alu_op       (alu_op),
    .imm          (imm),
    .sel_r        (sel_r),
    .dp_strobe    (dp_strobe),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every strobed cycle must match the oldest expected OP issue.
  always @(negedge clk) begin
    if (dp_strobe === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_strobe", 32'(sbq.size()), 32'd1);
      end else begin
        got_e = sbq.pop_front();
        chk("sb_ctrl", 32'({write_enable, sel_a, sel_b, alu_op, imm, sel_r}), 32'(got_e.ctrl));
        chk("sb_pc", 32'(pc), 32'(got_e.pc));
      end
    end
  end

  task automatic push_exp(input logic [11:0] instr, input logic [PC_W-1:0] at);
    exp_t e;
    e.ctrl = instr[9:0];
    e.pc   = at;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wr(input logic [PC_W-1:0] addr, input logic [11:0] data);
    @(negedge clk); prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic wait_for(input string tag, input bit want_halt);
    int n = 0;
    while ((want_halt ? !halted : busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 40), 32'd1);
  endtask

  initial begin
    // Reset held three cycles with start asserted
    @(negedge clk); reset = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'({write_enable, sel_a, sel_b, alu_op, imm, sel_r, dp_strobe, busy, halted}), 32'd0);
    chk("idle_pc", 32'(pc), 32'd0);
    for (int i = 0; i < 32; i++) wr(PC_W'(i), 12'hC00);

    // Single OP then HALT, with cycle-exact latency
    wr(5'd0, 12'h3C1); wr(5'd1, 12'hC00);
    push_exp(12'h3C1, 5'd0);
    pulse_start();
    chk("lat_fetch_busy", 32'(busy), 32'd1);
    chk("lat_fetch_strobe", 32'(dp_strobe), 32'd0);
    @(negedge clk);
    chk("lat_strobe", 32'(dp_strobe), 32'd1);
    chk("op_we", 32'(write_enable), 32'd1);
    chk("op_sel_a", 32'(sel_a), 32'd3);
    chk("op_sel_b", 32'(sel_b), 32'd2);
    chk("op_sel_r", 32'(sel_r), 32'd1);
    @(negedge clk);
    chk("strobe_one_cycle", 32'(dp_strobe), 32'd0);
    wait_for("halt1_timeout", 1'b1);
    chk("halt1_pc", 32'(pc), 32'd1);
    chk("halt1_busy", 32'(busy), 32'd0);
    chk("ctrl_hold", 32'(write_enable), 32'd1);

    // Branch taken / not taken
    wr(5'd0, 12'h0AA); wr(5'd1, 12'h805); wr(5'd5, 12'hC00);
    zero_flag = 1'b1;
    push_exp(12'h0AA, 5'd0);
    pulse_start();
    wait_for("bz_taken_timeout", 1'b1);
    chk("bz_taken_pc", 32'(pc), 32'd5);
    zero_flag = 1'b0;
    wr(5'd2, 12'hC00);
    push_exp(12'h0AA, 5'd0);
    pulse_start();
    wait_for("bz_fall_timeout", 1'b1);
    chk("bz_fall_pc", 32'(pc), 32'd2);
    chk("sb_empty_bz", 32'(sbq.size()), 32'd0);

    // Step through JMP to 31, then run across the wrap
    do_reset();
    wr(5'd0, 12'h41F); wr(5'd31, 12'h3E5); wr(5'd30, 12'hC00);
    pulse_step();
    wait_for("step_jmp_timeout", 1'b0);
    chk("step_jmp_pc", 32'(pc), 32'd31);
    wr(5'd0, 12'h41E);
    push_exp(12'h3E5, 5'd31);
    pulse_start();
    chk("wrap_pc31", 32'(pc), 32'd31);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_pc0", 32'(pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_pc30", 32'(pc), 32'd30);
    wait_for("wrap_halt_timeout", 1'b1);
    chk("wrap_halt_pc", 32'(pc), 32'd30);

    // Step mode; start while busy is ignored
    do_reset();
    for (int i = 0; i < 4; i++) wr(PC_W'(i), ops[i]);
    wr(5'd4, 12'hC00);
    for (int i = 0; i < 3; i++) begin
      push_exp(ops[i], PC_W'(i));
      pulse_step();
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("step_idle", 32'(busy), 32'd0);
      chk("step_pc", 32'(pc), 32'(i + 1));
    end
    chk("sb_empty_step", 32'(sbq.size()), 32'd0);

    // Stop during the second instruction of a run
    do_reset();
    push_exp(ops[0], 5'd0); push_exp(ops[1], 5'd1);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_pc", 32'(pc), 32'd2);
    chk("stop_not_halted", 32'(halted), 32'd0);

    // Program write while busy is ignored
    push_exp(ops[2], 5'd2); push_exp(ops[3], 5'd3);
    pulse_start();
    @(negedge clk); prog_we = 1'b1; prog_addr = 5'd3; prog_data = 12'hC00;
    @(negedge clk); prog_we = 1'b0;
    wait_for("busy_wr_timeout", 1'b1);
    chk("busy_wr_pc", 32'(pc), 32'd4);
    chk("sb_empty_busy_wr", 32'(sbq.size()), 32'd0);

    // Step ignored in HALT
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    chk("halt_ignores_step", 32'({halted, busy}), 32'b10);

    // Write and start in the same IDLE cycle: new HALT is fetched
    do_reset();
    @(negedge clk); prog_we = 1'b1; prog_addr = 5'd0; prog_data = 12'hC00; start = 1'b1;
    @(negedge clk); prog_we = 1'b0; start = 1'b0;
    chk("idle_wr_busy", 32'(busy), 32'd1);
    wait_for("idle_wr_timeout", 1'b1);
    chk("idle_wr_pc", 32'(pc), 32'd0);
    chk("sb_empty_final", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
